// File: rtl/can_rx_pkg.sv
// can_rx_pkg: shared constants and types for the CAN receive buffer.
//   FIFO_DEPTH / MAX_FRAME_BYTES : data FIFO size and per-frame byte limit
//   BASIC_RX_BASE / EXT_RX_BASE  : first host address of the receive window
//   rx_wr_state_t                : write-side state machine encoding
package can_rx_pkg;

    localparam int FIFO_DEPTH      = 64;
    localparam int MAX_FRAME_BYTES = 13;
    localparam int PTR_W           = $clog2(FIFO_DEPTH);

    localparam logic [7:0] BASIC_RX_BASE = 8'd20;
    localparam logic [7:0] EXT_RX_BASE   = 8'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        OVR    = 2'd2,
        COMMIT = 2'd3
    } rx_wr_state_t;

    // First address of the receive window for the selected mode.
    function automatic logic [7:0] rx_window_base(input logic ext);
        return ext ? EXT_RX_BASE : BASIC_RX_BASE;
    endfunction

    // Number of valid offsets in the receive window for the selected mode.
    function automatic logic [7:0] rx_window_len(input logic ext);
        return ext ? 8'd13 : 8'd10;
    endfunction

endpackage

// File: rtl/can_rx_len_fifo.sv
// can_rx_len_fifo: FIFO of committed frame lengths, one entry per frame.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   flush_i       : empties the FIFO (same effect as reset)
//   push_i/data_i : append a frame length
//   pop_i         : drop the head entry
//   head_o        : length of the oldest frame (combinational)
//   full_o/empty_o: occupancy flags
module can_rx_len_fifo
    import can_rx_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_idx_q, rd_idx_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_idx_q];

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i && !flush_i) begin
            mem_q[wr_idx_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_idx_q <= wr_idx_q + IDX_ONE;
            if (do_pop)  rd_idx_q <= rd_idx_q + IDX_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/can_rx_buffer.sv
// can_rx_buffer: 64-byte circular receive FIFO with a host read window.
//   clk, rst                 : clock, synchronous active-high reset
//   reset_mode               : holds the FIFO flushed while high
//   extended_mode            : window 16..28 (high) or 20..29 (low)
//   wr_en/wr_data            : byte strobe from the bit-stream processor
//   frame_done/frame_abort   : commit / discard the bytes of the current frame
//   addr, rx_data            : host address, registered read data (1 cycle)
//   release_buffer           : frees the oldest committed frame
//   clear_data_overrun       : clears the sticky overrun flag
//   receive_buffer_status    : at least one committed frame present
//   rx_message_counter       : committed frame count
//   data_overrun             : sticky overrun flag
//   fifo_fill                : occupied bytes, committed plus uncommitted
//   wr_state                 : current write-side state (debug observation)
module can_rx_buffer
    import can_rx_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         reset_mode,
    input  logic         extended_mode,
    input  logic         wr_en,
    input  logic [7:0]   wr_data,
    input  logic         frame_done,
    input  logic         frame_abort,
    input  logic [7:0]   addr,
    input  logic         release_buffer,
    input  logic         clear_data_overrun,
    output logic [7:0]   rx_data,
    output logic         receive_buffer_status,
    output logic [6:0]   rx_message_counter,
    output logic         data_overrun,
    output logic [6:0]   fifo_fill,
    output rx_wr_state_t wr_state
);

    // Pointers carry one extra wrap bit so a full FIFO (64) differs from empty.
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [3:0]     MAX_LEN  = 4'(MAX_FRAME_BYTES);

    rx_wr_state_t   state_q, state_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] cmt_ptr_q, cmt_ptr_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [6:0]     msg_cnt_q, msg_cnt_d;
    logic [3:0]     cur_len_q, cur_len_d;
    logic           ovr_q, ovr_d;
    logic [7:0]     rx_data_q;
    logic [7:0]     mem_q [FIFO_DEPTH];

    logic           store, push_len, do_release, set_ovr;
    logic           len_full, len_empty, fifo_full;
    logic [3:0]     head_len;
    logic [PTR_W:0] fill;
    logic [7:0]     rd_offset;
    logic           rd_valid;
    logic [PTR_W-1:0] rd_idx;

    assign fill      = wr_ptr_q - rd_ptr_q;
    assign fifo_full = (fill == FULL_CNT);

    can_rx_len_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_len_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (reset_mode),
        .push_i  (push_len),
        .data_i  (cur_len_q),
        .pop_i   (do_release),
        .head_o  (head_len),
        .full_o  (len_full),
        .empty_o (len_empty)
    );

    always_comb begin
        state_d    = state_q;
        cur_len_d  = cur_len_q;
        wr_ptr_d   = wr_ptr_q;
        cmt_ptr_d  = cmt_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        msg_cnt_d  = msg_cnt_q;
        ovr_d      = ovr_q;
        store      = 1'b0;
        push_len   = 1'b0;
        set_ovr    = 1'b0;
        do_release = 1'b0;

        case (state_q)
            IDLE, RECV: begin
                if (frame_abort) begin
                    wr_ptr_d  = cmt_ptr_q;
                    cur_len_d = '0;
                    state_d   = IDLE;
                end else if (frame_done && cur_len_q != '0) begin
                    state_d = COMMIT;
                end else if (wr_en) begin
                    // Fill is taken from registered pointers, so a release in
                    // this same cycle does not rescue the byte.
                    if (fifo_full || len_full) begin
                        set_ovr = 1'b1;
                        state_d = OVR;
                    end else if (cur_len_q < MAX_LEN) begin
                        store     = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PTR_ONE;
                        cur_len_d = cur_len_q + 4'd1;
                        state_d   = RECV;
                    end
                    // Bytes past the frame limit are dropped without overrun.
                end
            end
            OVR: begin
                if (frame_done || frame_abort) begin
                    wr_ptr_d  = cmt_ptr_q;
                    cur_len_d = '0;
                    state_d   = IDLE;
                end
            end
            COMMIT: begin
                // A byte strobed during this single cycle is not stored.
                push_len  = 1'b1;
                cmt_ptr_d = wr_ptr_q;
                cur_len_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (release_buffer && msg_cnt_q != '0 && !len_empty) begin
            do_release = 1'b1;
            rd_ptr_d   = rd_ptr_q + {3'b000, head_len};
        end

        case ({push_len, do_release})
            2'b10:   msg_cnt_d = msg_cnt_q + 7'd1;
            2'b01:   msg_cnt_d = msg_cnt_q - 7'd1;
            default: msg_cnt_d = msg_cnt_q;
        endcase

        if (set_ovr) begin
            ovr_d = 1'b1;
        end else if (clear_data_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || reset_mode) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            wr_ptr_q  <= '0;
            msg_cnt_q <= '0;
            cur_len_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            msg_cnt_q <= msg_cnt_d;
            cur_len_q <= cur_len_d;
            ovr_q     <= ovr_d;
        end
    end

    // Data RAM write port.
    always_ff @(posedge clk) begin
        if (store && !rst && !reset_mode) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
        end
    end

    // Addresses below the base wrap to large offsets and fail the length test.
    assign rd_offset = addr - rx_window_base(extended_mode);
    assign rd_valid  = (msg_cnt_q != '0) && (rd_offset < rx_window_len(extended_mode));
    assign rd_idx    = rd_ptr_q[PTR_W-1:0] + rd_offset[PTR_W-1:0];

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst || reset_mode) begin
            rx_data_q <= '0;
        end else if (rd_valid) begin
            rx_data_q <= mem_q[rd_idx];
        end else begin
            rx_data_q <= '0;
        end
    end

    assign rx_data               = rx_data_q;
    assign receive_buffer_status = (msg_cnt_q != '0);
    assign rx_message_counter    = msg_cnt_q;
    assign data_overrun          = ovr_q;
    assign fifo_fill             = fill;
    assign wr_state              = state_q;

endmodule

// File: tb/tb_can_rx_buffer.sv
module tb_can_rx_buffer;
    import can_rx_pkg::*;

    logic         clk = 1'b0;
    logic         rst, reset_mode, extended_mode;
    logic         wr_en, frame_done, frame_abort;
    logic [7:0]   wr_data, addr;
    logic         release_buffer, clear_data_overrun;
    logic [7:0]   rx_data;
    logic         receive_buffer_status;
    logic [6:0]   rx_message_counter;
    logic         data_overrun;
    logic [6:0]   fifo_fill;
    rx_wr_state_t wr_state;

    int n_checks = 0;
    int n_errors = 0;
    int bench_ptr = 0;   // where the next committed frame starts (mod 64)

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[14];

    can_rx_buffer dut (
        .clk                   (clk),
        .rst                   (rst),
        .reset_mode            (reset_mode),
        .extended_mode         (extended_mode),
        .wr_en                 (wr_en),
        .wr_data               (wr_data),
        .frame_done            (frame_done),
        .frame_abort           (frame_abort),
        .addr                  (addr),
        .release_buffer        (release_buffer),
        .clear_data_overrun    (clear_data_overrun),
        .rx_data               (rx_data),
        .receive_buffer_status (receive_buffer_status),
        .rx_message_counter    (rx_message_counter),
        .data_overrun          (data_overrun),
        .fifo_fill             (fifo_fill),
        .wr_state              (wr_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic write_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(base + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic commit();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
    endtask

    task automatic write_frame(input int n, input logic [7:0] base);
        write_bytes(n, base);
        commit();
        bench_ptr = (bench_ptr + ((n > MAX_FRAME_BYTES) ? MAX_FRAME_BYTES : n)) % FIFO_DEPTH;
    endtask

    task automatic do_release();
        release_buffer = 1'b1;
        tick();
        release_buffer = 1'b0;
    endtask

    // Scoreboard read: expectation queued when the address is driven,
    // popped and compared when the registered data appears.
    task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] e);
        logic [7:0] want;
        exp_q.push_back(e);
        addr = a;
        tick();
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got empty scoreboard expected one entry", name);
        end else begin
            want = exp_q.pop_front();
            chk(name, int'(rx_data), int'(want));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int pad, f0;
        rst = 1'b1; reset_mode = 1'b0; extended_mode = 1'b0;
        wr_en = 1'b0; wr_data = '0; frame_done = 1'b0; frame_abort = 1'b0;
        addr = 8'd0; release_buffer = 1'b0; clear_data_overrun = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("reset rx_data", int'(rx_data), 0);
        chk("reset status", int'(receive_buffer_status), 0);
        chk("reset counter", int'(rx_message_counter), 0);
        chk("reset overrun", int'(data_overrun), 0);
        chk("reset fill", int'(fifo_fill), 0);

        // ---- basic mode, table-driven window reads ----
        write_bytes(1, 8'h11);
        chk("fill after one byte", int'(fifo_fill), 1);
        write_bytes(9, 8'h12);
        chk("basic fill", int'(fifo_fill), 10);
        commit();
        bench_ptr = 10;
        chk("basic counter", int'(rx_message_counter), 1);
        chk("basic status", int'(receive_buffer_status), 1);

        for (int i = 0; i < 14; i++) begin
            vecs[i].addr = 8'(18 + i);
            vecs[i].exp  = (vecs[i].addr >= 8'd20 && vecs[i].addr <= 8'd29) ?
                           8'(8'h11 + vecs[i].addr - 8'd20) : 8'h00;
        end
        for (int i = 0; i < 14; i++) begin
            read_chk($sformatf("basic read addr %0d", vecs[i].addr), vecs[i].addr, vecs[i].exp);
        end

        do_release();
        chk("basic release counter", int'(rx_message_counter), 0);
        chk("basic release fill", int'(fifo_fill), 0);
        read_chk("read with no message", 8'd20, 8'h00);

        // ---- extended mode, two frames ----
        extended_mode = 1'b1;
        write_frame(13, 8'hA0);
        write_frame(5, 8'hB0);
        chk("ext counter 2", int'(rx_message_counter), 2);
        for (int i = 0; i < 13; i++) begin
            read_chk($sformatf("ext frame1 off %0d", i), 8'(16 + i), 8'(8'hA0 + i));
        end
        read_chk("ext addr 29 outside", 8'd29, 8'h00);
        read_chk("ext addr 15 outside", 8'd15, 8'h00);
        do_release();
        chk("ext counter 1", int'(rx_message_counter), 1);
        for (int i = 0; i < 5; i++) begin
            read_chk($sformatf("ext frame2 off %0d", i), 8'(16 + i), 8'(8'hB0 + i));
        end
        do_release();
        chk("ext counter 0", int'(rx_message_counter), 0);
        chk("ext status 0", int'(receive_buffer_status), 0);
        read_chk("ext empty read", 8'd16, 8'h00);

        // ---- wrap: place a 13-byte frame at 60..8 ----
        pad = (60 - bench_ptr + FIFO_DEPTH) % FIFO_DEPTH;
        while (pad > 0) begin
            int n;
            n = (pad > MAX_FRAME_BYTES) ? MAX_FRAME_BYTES : pad;
            write_frame(n, 8'h01);
            pad -= n;
        end
        while (rx_message_counter != 0) do_release();
        chk("wrap pre fill", int'(fifo_fill), 0);
        write_frame(13, 8'hC0);
        chk("wrap fill", int'(fifo_fill), 13);
        for (int i = 0; i < 13; i++) begin
            read_chk($sformatf("wrap off %0d", i), 8'(16 + i), 8'(8'hC0 + i));
        end
        do_release();

        // ---- overrun ----
        write_frame(13, 8'h40);
        write_frame(13, 8'h50);
        write_frame(13, 8'h60);
        write_frame(13, 8'h70);
        chk("ovr committed fill", int'(fifo_fill), 52);
        write_bytes(12, 8'h80);
        chk("ovr full fill", int'(fifo_fill), 64);
        chk("ovr not yet", int'(data_overrun), 0);
        wr_en = 1'b1; wr_data = 8'hFF; clear_data_overrun = 1'b1;
        tick();
        wr_en = 1'b0; clear_data_overrun = 1'b0;
        chk("ovr set beats clear", int'(data_overrun), 1);
        chk("ovr state", int'(wr_state), int'(OVR));
        write_bytes(1, 8'hEE);
        chk("ovr byte dropped", int'(fifo_fill), 64);
        commit();
        chk("ovr no new message", int'(rx_message_counter), 4);
        chk("ovr fill restored", int'(fifo_fill), 52);
        chk("ovr sticky", int'(data_overrun), 1);
        read_chk("ovr head intact", 8'd16, 8'h40);
        clear_data_overrun = 1'b1;
        tick();
        clear_data_overrun = 1'b0;
        chk("ovr cleared", int'(data_overrun), 0);
        while (rx_message_counter != 0) do_release();

        // ---- length limit, empty done, abort, commit+release ----
        write_frame(15, 8'h90);
        chk("long frame fill", int'(fifo_fill), 13);
        chk("long frame no overrun", int'(data_overrun), 0);
        read_chk("long frame last byte", 8'd28, 8'h9C);
        commit();
        chk("empty done ignored", int'(rx_message_counter), 1);
        f0 = int'(fifo_fill);
        write_bytes(4, 8'h30);
        chk("abort pre fill", int'(fifo_fill), f0 + 4);
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        chk("abort fill", int'(fifo_fill), f0);
        chk("abort counter", int'(rx_message_counter), 1);
        write_bytes(4, 8'hD0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        release_buffer = 1'b1;
        tick();
        release_buffer = 1'b0;
        chk("commit+release counter", int'(rx_message_counter), 1);
        chk("commit+release fill", int'(fifo_fill), 4);
        read_chk("commit+release head", 8'd16, 8'hD0);
        do_release();

        // ---- reset_mode mid-frame ----
        write_frame(3, 8'h21);
        write_frame(3, 8'h31);
        write_frame(3, 8'h41);
        write_bytes(2, 8'h51);
        read_chk("pre reset head", 8'd16, 8'h21);
        reset_mode = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        tick();
        reset_mode = 1'b0; wr_en = 1'b0;
        chk("rm rx_data", int'(rx_data), 0);
        chk("rm counter", int'(rx_message_counter), 0);
        chk("rm status", int'(receive_buffer_status), 0);
        chk("rm overrun", int'(data_overrun), 0);
        chk("rm fill", int'(fifo_fill), 0);
        chk("rm state", int'(wr_state), int'(IDLE));
        bench_ptr = 0;
        write_frame(2, 8'hE0);
        chk("post rm fill", int'(fifo_fill), 2);
        chk("post rm counter", int'(rx_message_counter), 1);
        read_chk("post rm byte0", 8'd16, 8'hE0);
        read_chk("post rm byte1", 8'd17, 8'hE1);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard drain: got %0d left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
